alu_result_mux_pipe: RTL

//  Parametrised, flow-controlled successor of the ALU result selector. It OR-combines the

---
 rtl/alu_pkg.sv | 7 +
 rtl/alu_skid_buf.sv | 40 ++++
 rtl/alu_result_mux_pipe.sv | 47 ++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types and defaults for the ALU result mux pipeline.
package alu_pkg;
   localparam int ALU_WIDTH_DEFAULT   = 32;
   localparam int ALU_NUM_SRC_DEFAULT = 3;
   typedef logic [ALU_WIDTH_DEFAULT-1:0] alu_data_t;
   typedef enum logic [1:0] {BUF_EMPTY, BUF_ONE, BUF_TWO} buf_state_e;
endpackage

// File: rtl/alu_skid_buf.sv
// alu_skid_buf: 2-entry valid/ready skid buffer; in_ready decodes only registered state.
module alu_skid_buf import alu_pkg::*; #(
   parameter int W = 33
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);
   buf_state_e state, state_nx;
   logic [W-1:0] main_q, skid_q;
   logic acc, xfer, load_main, load_skid;
   assign in_ready  = state != BUF_TWO;
   assign out_valid = state != BUF_EMPTY;
   assign out_data  = main_q;
   always_comb begin
      acc       = in_valid && in_ready;
      xfer      = out_valid && out_ready;
      state_nx  = state == BUF_EMPTY ? (acc ? BUF_ONE : BUF_EMPTY)
                : state == BUF_ONE   ? (acc && !xfer ? BUF_TWO : (!acc && xfer ? BUF_EMPTY : BUF_ONE))
                : (xfer ? BUF_ONE : BUF_TWO);
      load_main = (acc && (state == BUF_EMPTY || xfer)) || (state == BUF_TWO && xfer);
      load_skid = acc && state == BUF_ONE && !xfer;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= BUF_EMPTY;
         main_q <= '0;
         skid_q <= '0;
      end else begin
         state <= state_nx;
         if (load_main) main_q <= state == BUF_TWO ? skid_q : in_data;
         if (load_skid) skid_q <= in_data;
      end
   end
endmodule

// File: rtl/alu_result_mux_pipe.sv
// alu_result_mux_pipe: OR-combine of enabled ALU sources behind a skid-buffered handshake.
// Define ALU_RESULT_MUX_ONEHOT_CHECK_EN to flag non-one-hot selects on out_err/err_sticky.
module alu_result_mux_pipe import alu_pkg::*; #(
   parameter int WIDTH   = ALU_WIDTH_DEFAULT,
   parameter int NUM_SRC = ALU_NUM_SRC_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUM_SRC-1:0]       en,
   input  logic [NUM_SRC*WIDTH-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_err,
   output logic                     err_sticky
);
   logic [WIDTH-1:0] data;
   always_comb begin
      data = '0;
      for (int i = 0; i < NUM_SRC; i++) data |= en[i] ? in_data[i*WIDTH +: WIDTH] : '0;
   end
`ifdef ALU_RESULT_MUX_ONEHOT_CHECK_EN
   logic bad, sticky;
   logic [WIDTH:0] q;
   assign bad = !$onehot(en);
   alu_skid_buf #(.W(WIDTH + 1)) u_buf (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data({bad, data}),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(q)
   );
   assign out_data   = q[WIDTH-1:0];
   assign out_err    = q[WIDTH];
   assign err_sticky = sticky;
   always_ff @(posedge clk) begin
      if (!rst_n) sticky <= 1'b0;
      else if (in_valid && in_ready && bad) sticky <= 1'b1;
   end
`else
   alu_skid_buf #(.W(WIDTH)) u_buf (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );
   assign out_err    = 1'b0;
   assign err_sticky = 1'b0;
`endif
endmodule
